gelato_writeback_unit: RTL and testbench
========================================

// Module: gelato_writeback_unit
// PURPOSE
//  Producer end of the register writeback interface: gathers per-warp results from the compute,
//  memory and tensor execution units, buffers each source in its own FIFO, picks one entry per
//  cycle round-robin and drives a registered writeback (valid/ready) into the register file.
//  Sits between the exec units and the register file.
// PARAMETERS
//  SRC_NUM        3   result sources: 0 = compute, 1 = mem, 2 = tensor
//  THREAD_NUM     32  threads per warp (lanes)
//  DATA_WIDTH     32  bits per lane
//  WARP_ID_WIDTH  5   warp index width
//  REG_ID_WIDTH   5   architectural register index width
//  FIFO_DEPTH     4   entries per source FIFO; power of 2, >= 2
// PORTS
//  clk             in   1                          clock
//  rst             in   1                          asynchronous, active-high reset
//  rdy             in   1                          global enable; 0 = freeze all state
//  src_valid       in   SRC_NUM                    per-source result valid
//  src_ready       out  SRC_NUM                    per-source accept
//  src_warp_num    in   SRC_NUM*WARP_ID_WIDTH      per-source warp index (source i at slice i)
//  src_reg_num     in   SRC_NUM*REG_ID_WIDTH       per-source destination register
//  src_thread_mask in   SRC_NUM*THREAD_NUM         per-source lane write mask
//  src_data        in   SRC_NUM*THREAD_NUM*DATA_WIDTH per-source lane data
//  wb_valid        out  1                          writeback valid to the register file
//  wb_ready        in   1                          register file accepts the writeback
//  wb_warp_num     out  WARP_ID_WIDTH              writeback warp index
//  wb_reg_num      out  REG_ID_WIDTH               writeback destination register
//  wb_thread_mask  out  THREAD_NUM                 writeback lane mask
//  wb_data         out  THREAD_NUM*DATA_WIDTH      writeback lane data
//  busy            out  1                          any FIFO non-empty OR wb_valid
// BEHAVIOUR
//  - Reset (rst high, async): FIFOs empty, wb_valid=0, all wb_* payload=0, rr_ptr=SRC_NUM-1,
//    src_ready=0 while rst is high, busy=0.
//  - src_ready[i] = rdy & ~full[i]. Push when src_valid[i] & src_ready[i]. No push into a full
//    FIFO, even when it pops in the same cycle (ready depends on the registered count only).
//  - Output stage states: IDLE (wb_valid=0) and HOLD (wb_valid=1).
//    load = rdy & (IDLE | wb_ready) & any FIFO non-empty. On load the granted FIFO head moves
//    into the output register; state goes to/stays HOLD.
//    In HOLD with wb_ready=1 and no load -> IDLE. In HOLD with wb_ready=0 -> payload held stable.
//  - Arbitration: scan for a non-empty FIFO from rr_ptr+1 upward, mod SRC_NUM. rr_ptr takes the
//    granted index, and only changes on a load.
//  - Latency: a result accepted at edge N into an empty unit shows wb_valid=1 after edge N+1.
//    Throughput: 1 writeback/cycle while wb_ready=1.
//  - Push and pop of the same FIFO in one cycle: occupancy unchanged, ordering preserved.
//    Per-source order is FIFO.
//  - Occupancy counters are clog2(FIFO_DEPTH)+1 bits. Read and write pointers wrap mod FIFO_DEPTH.
//  - rdy=0: no push, no load, no state, pointer or rr_ptr change. wb_valid and payload hold.
//    A wb_ready pulse while rdy=0 does not retire the entry.
//  - rst asserted mid-operation: all buffered and in-flight entries are discarded; no partial
//    writeback is emitted afterwards.
// CONFIGURATION
//  GELATO_WB_ZERO_REG_DROP_EN defined: a pushed entry with reg_num==0 still completes the
//    src handshake, but it is not written to the FIFO and never reaches wb_*.
//  Not defined: reg_num==0 entries are forwarded like any other register.
// TESTING
//  1 Reset, then src0 pushes warp=3 reg=7 mask=0xFFFFFFFF data=lane-index, wb_ready=1 ->
//    wb_valid for exactly one cycle, 2 edges after the push, with the identical payload.
//  2 All three sources push every cycle, wb_ready=1 -> writeback source order 0,1,2,0,1,2...,
//    one per cycle, no loss.
//  3 wb_ready=0, src1 pushes 5 entries -> src_ready[1]=0 after 4 FIFO entries plus 1 held in
//    the output register. wb_valid and payload stay stable. Release wb_ready -> all 5 emerge in order.
//  4 FIFO full with simultaneous pop and src_valid=1 -> no push that cycle; push succeeds the
//    next cycle; count never exceeds FIFO_DEPTH.
//  5 rdy=0 for 3 cycles during HOLD with wb_ready=1 -> no retire, no accept. On rdy=1, resumes
//    with no duplicate and no drop.
//  6 Push reg=0, warp=2 -> with GELATO_WB_ZERO_REG_DROP_EN: no wb_valid and busy stays 0;
//    without it: one writeback with reg=0.

Source files
------------

// File: rtl/gelato_writeback_unit.sv
// gelato_writeback_unit: register-file writeback producer.
// One FIFO per result source (compute, mem, tensor). A round-robin arbiter
// moves one FIFO head per cycle into a registered valid/ready output stage.
// Optional feature macro: GELATO_WB_ZERO_REG_DROP_EN. When defined, results
// aimed at register 0 are handshaked but silently discarded.

// Per-source result FIFO; caller guarantees no push when full, no pop when empty.
module gelato_wb_src_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]             cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; pointers wrap mod DEPTH.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state resets; storage contents do not need to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

module gelato_writeback_unit #(
  parameter int SRC_NUM       = 3,
  parameter int THREAD_NUM    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WARP_ID_WIDTH = 5,
  parameter int REG_ID_WIDTH  = 5,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     rdy,
  input  logic [SRC_NUM-1:0]                       src_valid,
  output logic [SRC_NUM-1:0]                       src_ready,
  input  logic [SRC_NUM*WARP_ID_WIDTH-1:0]         src_warp_num,
  input  logic [SRC_NUM*REG_ID_WIDTH-1:0]          src_reg_num,
  input  logic [SRC_NUM*THREAD_NUM-1:0]            src_thread_mask,
  input  logic [SRC_NUM*THREAD_NUM*DATA_WIDTH-1:0] src_data,
  output logic                                     wb_valid,
  input  logic                                     wb_ready,
  output logic [WARP_ID_WIDTH-1:0]                 wb_warp_num,
  output logic [REG_ID_WIDTH-1:0]                  wb_reg_num,
  output logic [THREAD_NUM-1:0]                    wb_thread_mask,
  output logic [THREAD_NUM*DATA_WIDTH-1:0]         wb_data,
  output logic                                     busy
);
  localparam int IDX_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
  localparam int LD_W  = THREAD_NUM * DATA_WIDTH;

  typedef struct packed {
    logic [WARP_ID_WIDTH-1:0] warp;
    logic [REG_ID_WIDTH-1:0]  reg_num;
    logic [THREAD_NUM-1:0]    mask;
    logic [LD_W-1:0]          data;
  } wb_ent_t;

  localparam int EW = $bits(wb_ent_t);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} wb_state_e;

  wb_ent_t [SRC_NUM-1:0] src_ent, fifo_head;
  logic    [SRC_NUM-1:0] full, empty, push, wr_en, pop;

  wb_state_e  state_q;
  wb_ent_t    wb_q;
  logic [IDX_W-1:0] rr_ptr_q, grant_idx;
  logic       grant_found;
  logic       load;

  // One FIFO per source; handshake depends only on registered occupancy.
  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    assign src_ent[i] = {src_warp_num[i*WARP_ID_WIDTH +: WARP_ID_WIDTH],
                         src_reg_num[i*REG_ID_WIDTH +: REG_ID_WIDTH],
                         src_thread_mask[i*THREAD_NUM +: THREAD_NUM],
                         src_data[i*LD_W +: LD_W]};
    assign src_ready[i] = rdy & ~full[i] & ~rst;
    assign push[i]      = src_valid[i] & src_ready[i];
`ifdef GELATO_WB_ZERO_REG_DROP_EN
    // Writes to r0 are architecturally dead: accept, then discard.
    assign wr_en[i]     = push[i] & (src_reg_num[i*REG_ID_WIDTH +: REG_ID_WIDTH] != '0);
`else
    assign wr_en[i]     = push[i];
`endif
    assign pop[i]       = load & (grant_idx == IDX_W'(i));

    gelato_wb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en[i]),
      .pop   (pop[i]),
      .din   (src_ent[i]),
      .dout  (fifo_head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Round-robin: first non-empty source scanning upward from rr_ptr+1.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_idx   = rr_ptr_q;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= SRC_NUM; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % SRC_NUM);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load = rdy & ((state_q == IDLE) | wb_ready) & grant_found;

  // Output stage FSM: loads the granted head, retires on wb_ready, freezes on !rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_q     <= '0;
      rr_ptr_q <= IDX_W'(SRC_NUM - 1);
    end else if (load) begin
      state_q  <= HOLD;
      wb_q     <= fifo_head[grant_idx];
      rr_ptr_q <= grant_idx;
    end else if (rdy && (state_q == HOLD) && wb_ready) begin
      state_q  <= IDLE;
    end
  end

  assign wb_valid       = (state_q == HOLD);
  assign wb_warp_num    = wb_q.warp;
  assign wb_reg_num     = wb_q.reg_num;
  assign wb_thread_mask = wb_q.mask;
  assign wb_data        = wb_q.data;
  assign busy           = (~&empty) | wb_valid;
endmodule

// File: tb/tb_gelato_writeback_unit.sv
// Bench for gelato_writeback_unit: directed scenarios plus a random phase,
// checked every cycle against a queue-based transaction model.
module tb_gelato_writeback_unit;
  localparam int SN = 3, TN = 32, DW = 32, WW = 5, RW = 5, DEPTH = 4;
  localparam int LD = TN * DW;
`ifdef GELATO_WB_ZERO_REG_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [WW-1:0] warp;
    logic [RW-1:0] rg;
    logic [TN-1:0] mask;
    logic [LD-1:0] data;
  } ent_t;

  logic clk = 1'b0, rst, rdy, wb_ready, wb_valid, busy;
  logic [SN-1:0] src_valid, src_ready;
  logic [SN*WW-1:0] src_warp_num;
  logic [SN*RW-1:0] src_reg_num;
  logic [SN*TN-1:0] src_thread_mask;
  logic [SN*LD-1:0] src_data;
  logic [WW-1:0] wb_warp_num;
  logic [RW-1:0] wb_reg_num;
  logic [TN-1:0] wb_thread_mask;
  logic [LD-1:0] wb_data;

  ent_t in_e [SN];
  ent_t mq [SN][$];
  logic mv;
  ent_t mp;
  int   rr;
  int   n_asrt = 0, n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    src_warp_num = '0; src_reg_num = '0; src_thread_mask = '0; src_data = '0;
    for (int i = 0; i < SN; i++) begin
      src_warp_num[i*WW +: WW]    = in_e[i].warp;
      src_reg_num[i*RW +: RW]     = in_e[i].rg;
      src_thread_mask[i*TN +: TN] = in_e[i].mask;
      src_data[i*LD +: LD]        = in_e[i].data;
    end
  end

  gelato_writeback_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_warp_num(src_warp_num), .src_reg_num(src_reg_num),
    .src_thread_mask(src_thread_mask), .src_data(src_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_warp_num(wb_warp_num), .wb_reg_num(wb_reg_num),
    .wb_thread_mask(wb_thread_mask), .wb_data(wb_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.warp = WW'($urandom);
    e.rg   = RW'($urandom);
    e.mask = $urandom;
    for (int l = 0; l < TN; l++) e.data[l*DW +: DW] = $urandom;
    return e;
  endfunction

  function automatic bit model_busy();
    bit b = mv;
    for (int i = 0; i < SN; i++) if (mq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Output-side comparison against the model after an edge.
  task automatic chk_out();
    chk("wb_valid", wb_valid, mv);
    chk("wb_warp", wb_warp_num, mp.warp);
    chk("wb_reg", wb_reg_num, mp.rg);
    chk("wb_mask", wb_thread_mask, mp.mask);
    chk("wb_data_lo", wb_data[511:0], mp.data[511:0]);
    chk("wb_data_hi", wb_data[LD-1:512], mp.data[LD-1:512]);
    chk("busy", busy, model_busy());
  endtask

  // One clock: check src_ready, advance the model by the transaction rules, clock, compare.
  task automatic step();
    logic [SN-1:0] acc;
    bit any, ld;
    int g;
    ent_t head;
    #1;
    acc = '0; any = 0; g = -1; head = '0;
    for (int i = 0; i < SN; i++) begin
      acc[i] = rdy && (mq[i].size() < DEPTH);
      if (mq[i].size() > 0) any = 1;
    end
    chk("src_ready", src_ready, acc);
    acc = acc & src_valid;
    ld = rdy && (!mv || wb_ready) && any;
    if (ld) begin
      for (int k = 1; k <= SN; k++)
        if (g < 0 && mq[(rr + k) % SN].size() > 0) g = (rr + k) % SN;
      head = mq[g].pop_front();
    end
    for (int i = 0; i < SN; i++)
      if (acc[i] && !(DROP && in_e[i].rg == '0)) mq[i].push_back(in_e[i]);
    if (ld) begin
      mv = 1'b1; mp = head; rr = g;
    end else if (rdy && mv && wb_ready) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_out();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_src_ready", src_ready, '0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_reg", wb_reg_num, '0);
    chk("rst_wb_data", wb_data[511:0], '0);
    for (int i = 0; i < SN; i++) mq[i].delete();
    mv = 1'b0; mp = '0; rr = SN - 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    src_valid = '0; wb_ready = 1'b1; rdy = 1'b1;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    ent_t e;
    rst = 1'b1; rdy = 1'b1; wb_ready = 1'b0; src_valid = '0;
    for (int i = 0; i < SN; i++) in_e[i] = '0;
    mv = 1'b0; mp = '0; rr = SN - 1;
    do_reset();

    // 1: single result, two-edge latency, one-cycle wb_valid, identical payload
    e.warp = 5'd3; e.rg = 5'd7; e.mask = 32'hFFFF_FFFF;
    for (int l = 0; l < TN; l++) e.data[l*DW +: DW] = DW'(l);
    in_e[0] = e; src_valid = 3'b001; wb_ready = 1'b1;
    step();
    chk("t1_no_valid_yet", wb_valid, 1'b0);
    src_valid = '0;
    step();
    chk("t1_valid", wb_valid, 1'b1);
    chk("t1_data_lo", wb_data[511:0], e.data[511:0]);
    chk("t1_data_hi", wb_data[LD-1:512], e.data[LD-1:512]);
    step();
    chk("t1_one_cycle", wb_valid, 1'b0);

    // 2: all sources push every cycle, full throughput round robin
    src_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < SN; i++) in_e[i] = rnd_ent();
      step();
    end
    drain(16);

    // 3: wb_ready low, src1 fills FIFO plus output register, then releases
    wb_ready = 1'b0; src_valid = 3'b010;
    for (int c = 0; c < 7; c++) begin
      in_e[1] = rnd_ent();
      step();
    end
    chk("t3_backpressure", src_ready[1], 1'b0);
    drain(8);

    // 4: full FIFO with simultaneous pop and valid -> push deferred one cycle
    wb_ready = 1'b0; src_valid = 3'b001;
    for (int c = 0; c < 6; c++) begin
      in_e[0] = rnd_ent();
      step();
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_e[0] = rnd_ent();
      step();
    end
    drain(8);

    // 5: rdy low during HOLD with wb_ready high freezes everything
    wb_ready = 1'b0; src_valid = 3'b100; in_e[2] = rnd_ent();
    step();
    src_valid = '0;
    step();
    wb_ready = 1'b1; rdy = 1'b0; src_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < SN; i++) in_e[i] = rnd_ent();
      step();
    end
    drain(6);

    // 6: reg 0 result (dropped or forwarded depending on build)
    e = rnd_ent(); e.warp = 5'd2; e.rg = '0;
    in_e[0] = e; src_valid = 3'b001;
    step();
    src_valid = '0;
    step();
    chk("t6_zero_reg_valid", wb_valid, !DROP);
    drain(3);

    // Random phase with a mid-run reset
    for (int c = 0; c < 400; c++) begin
      src_valid = SN'($urandom);
      wb_ready  = ($urandom_range(0, 3) != 0);
      rdy       = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < SN; i++) begin
        in_e[i] = rnd_ent();
        if ($urandom_range(0, 7) == 0) in_e[i].rg = '0;
      end
      step();
      if (c == 200) do_reset();
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
